// File: rtl/pipeline_id_q.sv
// pipeline_id_q: decode stage with instruction queue, load-use interlock and valid/ready handshakes
`define OpSelWidth 5
`define OpNOP 5'd0
`define OpADD 5'd1
`define OpSUB 5'd2
`define OpSLL 5'd3
`define OpSLT 5'd4
`define OpSLTU 5'd5
`define OpXOR 5'd6
`define OpSRL 5'd7
`define OpSRA 5'd8
`define OpOR 5'd9
`define OpAND 5'd10
`define OpLUI 5'd11
`define OpAUIPC 5'd12
`define OpJAL 5'd13
`define OpJALR 5'd14
`define OpBEQ 5'd15
`define OpBNE 5'd16
`define OpBLT 5'd17
`define OpBGE 5'd18
`define OpBLTU 5'd19
`define OpBGEU 5'd20
`define OpLB 5'd21
`define OpLH 5'd22
`define OpLW 5'd23
`define OpLBU 5'd24
`define OpLHU 5'd25
`define OpSB 5'd26
`define OpSH 5'd27
`define OpSW 5'd28

module pipeline_id_q #(
  parameter int XLEN = 32,
  parameter int QDEPTH = 4,
  parameter int LOAD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_valid_i,
  input  logic [31:0]              if_inst_i,
  input  logic [XLEN-1:0]          if_pc_i,
  output logic                     if_ready_o,
  input  logic                     flush_i,
  output logic                     reg_re1_o,
  output logic                     reg_re2_o,
  output logic [4:0]               reg_ra1_o,
  output logic [4:0]               reg_ra2_o,
  input  logic [XLEN-1:0]          val1_i,
  input  logic [XLEN-1:0]          val2_i,
  output logic                     ex_valid_o,
  input  logic                     ex_ready_i,
  output logic [XLEN-1:0]          val1_o,
  output logic [XLEN-1:0]          val2_o,
  output logic [XLEN-1:0]          imm_o,
  output logic [4:0]               rd_o,
  output logic                     we_o,
  output logic [1:0]               optype_o,
  output logic [`OpSelWidth-1:0]   opsel_o,
  output logic [4:0]               rs1_o,
  output logic [4:0]               rs2_o,
  output logic                     rs1_e_o,
  output logic                     rs2_e_o,
  output logic [XLEN-1:0]          pc_o,
  output logic [$clog2(QDEPTH):0]  count_o
);
  localparam int AW = $clog2(QDEPTH);
  typedef struct packed {
    logic [`OpSelWidth-1:0] op;
    logic [1:0] ty;
    logic [4:0] rd, rs1, rs2;
    logic we, re1, re2;
    logic [31:0] imm;
  } dec_t;
  typedef struct packed {
    logic v;
    logic [XLEN-1:0] val1, val2, imm, pc;
    logic [4:0] rd, rs1, rs2;
    logic we, re1, re2;
    logic [1:0] ty;
    logic [`OpSelWidth-1:0] op;
  } ex_t;

  function automatic logic [`OpSelWidth-1:0] alu_op(input logic [2:0] f, input logic alt);
    return f == 3'd0 ? `OpADD : f == 3'd1 ? `OpSLL : f == 3'd2 ? `OpSLT : f == 3'd3 ? `OpSLTU :
           f == 3'd4 ? `OpXOR : f == 3'd5 ? (alt ? `OpSRA : `OpSRL) : f == 3'd6 ? `OpOR : `OpAND;
  endfunction

  // Illegal encodings collapse to an all-zero NOP so they never read registers or stall.
  function automatic dec_t decode(input logic [31:0] i);
    dec_t d;
    logic [2:0] f;
    f = i[14:12];
    d = '0;
    case (i[6:0])
      7'b0110011: begin
        d.op = (f == 3'd0 && i[30]) ? `OpSUB : alu_op(f, i[30]);
        {d.ty, d.we, d.re1, d.re2} = {2'd1, 3'b111};
      end
      7'b0010011: begin
        d.op = alu_op(f, i[30]);
        {d.ty, d.we, d.re1} = {2'd1, 2'b11};
        d.imm = {{20{i[31]}}, i[31:20]};
      end
      7'b0000011: begin
        d.op = f == 3'd0 ? `OpLB : f == 3'd1 ? `OpLH : f == 3'd2 ? `OpLW :
               f == 3'd4 ? `OpLBU : f == 3'd5 ? `OpLHU : `OpNOP;
        {d.ty, d.we, d.re1} = {2'd2, 2'b11};
        d.imm = {{20{i[31]}}, i[31:20]};
      end
      7'b0100011: begin
        d.op = f == 3'd0 ? `OpSB : f == 3'd1 ? `OpSH : f == 3'd2 ? `OpSW : `OpNOP;
        {d.ty, d.re1, d.re2} = {2'd2, 2'b11};
        d.imm = {{20{i[31]}}, i[31:25], i[11:7]};
      end
      7'b1100011: begin
        d.op = f == 3'd0 ? `OpBEQ : f == 3'd1 ? `OpBNE : f == 3'd4 ? `OpBLT :
               f == 3'd5 ? `OpBGE : f == 3'd6 ? `OpBLTU : f == 3'd7 ? `OpBGEU : `OpNOP;
        {d.ty, d.re1, d.re2} = {2'd3, 2'b11};
        d.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      end
      7'b0110111: {d.op, d.ty, d.we, d.imm} = {`OpLUI, 2'd1, 1'b1, i[31:12], 12'd0};
      7'b0010111: {d.op, d.ty, d.we, d.imm} = {`OpAUIPC, 2'd1, 1'b1, i[31:12], 12'd0};
      7'b1101111: begin
        {d.op, d.ty, d.we} = {`OpJAL, 2'd3, 1'b1};
        d.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      end
      7'b1100111: begin
        d.op = f == 3'd0 ? `OpJALR : `OpNOP;
        {d.ty, d.we, d.re1} = {2'd3, 2'b11};
        d.imm = {{20{i[31]}}, i[31:20]};
      end
      default: d.op = `OpNOP;
    endcase
    d.rd = d.we ? i[11:7] : 5'd0;
    d.rs1 = d.re1 ? i[19:15] : 5'd0;
    d.rs2 = d.re2 ? i[24:20] : 5'd0;
    if (d.op == `OpNOP) d = '0;
    return d;
  endfunction

  logic [31:0] inst_q [QDEPTH];
  logic [XLEN-1:0] pc_q [QDEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q, cnt_d;
  logic [LOAD_LAT-1:0] sbv_q;
  logic [LOAD_LAT-1:0][4:0] sbrd_q;
  ex_t ex_q, ex_d, ex_i, ex_z;
  dec_t hd;
  logic [XLEN-1:0] head_pc;
  logic head_v, haz, adv, issue, enq, ld;

  assign hd = decode(inst_q[rp_q]);
  assign head_pc = pc_q[rp_q];
  assign head_v = cnt_q != '0;
  assign if_ready_o = cnt_q != (AW+1)'(QDEPTH);
  assign adv = !ex_q.v || ex_ready_i;
  assign enq = if_valid_i && if_ready_o && !flush_i;
  assign issue = head_v && !haz && adv && !flush_i;
  assign ld = hd.rd != 5'd0 && hd.op inside {`OpLB, `OpLH, `OpLW, `OpLBU, `OpLHU};
  assign cnt_d = cnt_q + (AW+1)'(enq) - (AW+1)'(issue);
  assign reg_re1_o = !rst && head_v && hd.re1;
  assign reg_re2_o = !rst && head_v && hd.re2;
  assign reg_ra1_o = reg_re1_o ? hd.rs1 : 5'd0;
  assign reg_ra2_o = reg_re2_o ? hd.rs2 : 5'd0;
  assign count_o = cnt_q;

  // head must wait while any in-flight load still owes one of its source registers
  always_comb begin
    haz = 1'b0;
    for (int k = 0; k < LOAD_LAT; k++)
      haz |= sbv_q[k] && ((hd.re1 && hd.rs1 == sbrd_q[k]) || (hd.re2 && hd.rs2 == sbrd_q[k]));
    haz &= head_v;
  end

  // next output register: issue loads the head, a free slot without issue becomes a bubble
  always_comb begin
    ex_z = '0;
    ex_z.op = `OpNOP;
    ex_i = '{v: 1'b1, val1: hd.op == `OpAUIPC ? head_pc : val1_i, val2: val2_i,
             imm: XLEN'($signed(hd.imm)), pc: head_pc, rd: hd.rd, rs1: hd.rs1, rs2: hd.rs2,
             we: hd.we, re1: hd.re1, re2: hd.re2, ty: hd.ty, op: hd.op};
    ex_d = issue ? ex_i : adv ? ex_z : ex_q;
  end

  // queue storage needs no reset; occupancy alone decides which entries are live
  always_ff @(posedge clk) begin
    if (enq) begin
      inst_q[wp_q] <= if_inst_i;
      pc_q[wp_q] <= if_pc_i;
    end
  end

  // pointers, occupancy and output register
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_q + AW'(enq);
      rp_q <= rp_q + AW'(issue);
      cnt_q <= cnt_d;
    end
    ex_q <= (rst || flush_i) ? ex_z : ex_d;
  end

  // load scoreboard shifts only when the output register advances
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      sbv_q <= '0;
      sbrd_q <= '0;
    end else if (adv) begin
      sbv_q[0] <= issue && ld;
      sbrd_q[0] <= (issue && ld) ? hd.rd : 5'd0;
      for (int k = 1; k < LOAD_LAT; k++) begin
        sbv_q[k] <= sbv_q[k-1];
        sbrd_q[k] <= sbrd_q[k-1];
      end
    end
  end

  assign ex_valid_o = ex_q.v;
  assign val1_o = ex_q.val1;
  assign val2_o = ex_q.val2;
  assign imm_o = ex_q.imm;
  assign rd_o = ex_q.rd;
  assign we_o = ex_q.we;
  assign optype_o = ex_q.ty;
  assign opsel_o = ex_q.op;
  assign rs1_o = ex_q.rs1;
  assign rs2_o = ex_q.rs2;
  assign rs1_e_o = ex_q.re1;
  assign rs2_e_o = ex_q.re2;
  assign pc_o = ex_q.pc;
endmodule

// File: doc/pipeline_id_q.md
Name: pipeline_id_q

Overview:
Decode stage with a built-in instruction queue. It sits between IF and EX, and uses the existing `decoder` module combinationally on the queue head. It replaces the fixed stall/flush-vector coupling with a valid/ready handshake on both sides. It adds a parametrised instruction queue and a configurable load-use interlock window.

Parameters:
XLEN, 32, data and PC width.
QDEPTH, 4, instruction queue entries; power of 2, at least 2.
LOAD_LAT, 1, bubbles required between a load and a dependent consumer; range 1..3.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
if_valid_i  in  1  IF offers {if_inst_i, if_pc_i}
if_inst_i  in  32  fetched instruction
if_pc_i  in  XLEN  PC of fetched instruction
if_ready_o  out  1  queue can accept; equals (count_o != QDEPTH)
flush_i  in  1  redirect: discard queue, output register and scoreboard
reg_re1_o / reg_re2_o  out  1  register-file read enables (from queue head)
reg_ra1_o / reg_ra2_o  out  5  register-file read addresses (from queue head)
val1_i / val2_i  in  XLEN  register-file read data (same cycle)
ex_valid_o  out  1  EX output register holds a real instruction
ex_ready_i  in  1  EX accepts the output register this cycle
val1_o, val2_o, imm_o  out  XLEN  operands and immediate
rd_o  out  5  destination register
we_o  out  1  destination write enable
optype_o  out  2  operation class
opsel_o  out  `OpSelWidth  operation select
rs1_o, rs2_o  out  5  source addresses, for forwarding
rs1_e_o, rs2_e_o  out  1  source read enables
pc_o  out  XLEN  PC of the issued instruction
count_o  out  $clog2(QDEPTH)+1  queue occupancy

Behaviour:
- Reset: count_o=0, if_ready_o=1 from the cycle after reset. All EX outputs are 0, including ex_valid_o, opsel_o=`OpNOP and optype_o=2'b00. Scoreboard is cleared. reg_* outputs are 0 while rst=1.
- Queue: circular buffer of {inst, pc} with wrapping read/write pointers.
  - Enqueue when if_valid_i && if_ready_o.
  - if_ready_o depends only on count_o. When full, no enqueue is allowed even if a dequeue happens in the same cycle.
  - Simultaneous enqueue and dequeue leaves count_o unchanged.
- Head decode: the head is valid when count_o>0. reg_re*/reg_ra* come from the decoder on the head. When count_o=0 they are 0.
- Advance condition: adv = !ex_valid_o || ex_ready_i.
- Hazard:
  - The scoreboard is LOAD_LAT entries of {valid, rd}, shifted on each adv.
  - The inserted entry is {1, rd} if the instruction issued that cycle is a load (`OpLB`, `OpLH`, `OpLW`, `OpLBU`, `OpLHU`) with rd!=0; otherwise {0, 0}.
  - haz = head valid && ((re1 && rs1 matches any valid entry) || (re2 && rs2 matches any valid entry)).
- Issue:
  - Condition: issue = head valid && !haz && adv && !flush_i. Issue dequeues the head.
  - The output register loads the decoded fields, val1_i/val2_i and pc.
  - val1_o = pc when opsel=`OpAUIPC`.
  - rs*_e_o = re*; ex_valid_o=1.
- Bubble: adv && !issue → ex_valid_o=0 and all EX outputs are cleared to reset values.
- Hold: ex_valid_o && !ex_ready_i → all EX outputs and the scoreboard hold.
- Latency: an instruction enqueued at cycle N issues no earlier than N+1. The queue has no same-cycle bypass.
- Flush (takes priority over everything except rst):
  - Pointers, count, scoreboard and the output register are cleared; ex_valid_o=0 the next cycle.
  - An enqueue in the flush cycle is dropped.
  - if_ready_o=1 the next cycle.
- Illegal opcode: issues as `OpNOP` with we=0. It never stalls.
- Reset mid-operation: identical to the reset state next cycle, regardless of queue contents.

Test Plan:
- Stream: 6 ADDI back-to-back, ex_ready_i=1 → one issue per cycle from cycle 2. count_o stays ≤1 and pc_o increments by 4.
- Backpressure: ex_ready_i=0 for 8 cycles while IF offers → count_o saturates at 4 and if_ready_o=0. Outputs hold the first instruction. On ready, queued entries drain in order and none is lost.
- Load-use, LOAD_LAT=1: LW x5 then ADD x6,x5,x7 → exactly 1 bubble (ex_valid_o=0) between them. With LOAD_LAT=2 → 2 bubbles. LW x0 followed by a consumer of x0 → no bubble.
- AUIPC at pc=0x100 → val1_o=0x100, opsel_o=`OpAUIPC`. Separately, `OpLHU` with funct3=101 decodes to `OpLHU`.
- Flush with 3 queued entries plus a valid output, and if_valid_i=1 in the same cycle → next cycle count_o=0, ex_valid_o=0, and the instruction offered in the flush cycle is not enqueued.
- Wrap: 20 instructions with random ex_ready_i stalls, QDEPTH=4 → EX order and PCs match the IF order exactly.
